// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder sequencer: FSM states and slice width.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add16_my_add.sv
// Existing 4-bit combinational ripple adder reused one nibble at a time by serial_add16.
module my_add
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  // One nibble of A + B + carry-in, with the fifth bit becoming the carry-out.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
  end

endmodule

// File: rtl/serial_add16.sv
// Multi-nibble serial adder: accepts wide operands, adds them one nibble per
// cycle LSB first through a single my_add, and returns sum, carry and overflow.
module serial_add16
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                             state;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   op_a;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   op_b;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_reg;
  logic [IDX_W-1:0]                   idx;
  logic                               carry;
  logic                               cout_reg;
  logic                               ovf_reg;

  logic [NIBBLE_W-1:0]                slice_a;
  logic [NIBBLE_W-1:0]                slice_b;
  logic [NIBBLE_W-1:0]                slice_s;
  logic                               slice_co;
  logic                               ovf_next;

  // Select the active nibble of each latched operand for the shared adder.
  always_comb begin
    slice_a = op_a[idx];
    slice_b = op_b[idx];
  end

  my_add u_add (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Signed overflow: operand signs agree but the final nibble's sign bit differs.
  always_comb begin
    ovf_next = (op_a[NIBBLES-1][NIBBLE_W-1] == op_b[NIBBLES-1][NIBBLE_W-1]) &&
               (slice_s[NIBBLE_W-1] != op_a[NIBBLES-1][NIBBLE_W-1]);
  end

  // Sequencer FSM: latch operands, walk the nibbles, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sum_reg  <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= in_a;
            op_b     <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx] <= slice_s;
          carry        <= slice_co;
          if (idx == LAST_IDX) begin
            cout_reg <= slice_co;
            ovf_reg  <= ovf_next;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status flags come straight from the state register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add16.sv
// Directed self-checking bench for serial_add16 (default 4 nibbles, 16-bit operands).
module tb_serial_add16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  int tests_run;
  int tests_failed;
  int cycle_count;
  int accept_cycle;
  int prev_accept;
  int latency;

  serial_add16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure latency and initiation interval.
  initial cycle_count = 0;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present an operand pair and wait (bounded) for the acceptance edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin);
    int waited;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("accept_wait_bound", 32'(waited < 20), 32'd1);
    @(posedge clk); #1;
    accept_cycle = cycle_count;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, recording cycles since acceptance.
  task automatic waitResult();
    latency = 0;
    while (!out_valid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  // Check the presented result against a reference computed from the operands.
  task automatic checkResult(input string tag, input logic [15:0] a,
                             input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {16'h0, cin};
    ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sum"},   32'(out_sum),   32'(full[15:0]));
    checkOutput({tag, "_cout"},  32'(out_cout),  32'(full[16]));
    checkOutput({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
  endtask

  // Take the pending result with a one-cycle out_ready pulse.
  task automatic consumeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    tests_run    = 0;
    tests_failed = 0;
    prev_accept  = 0;
    accept_cycle = 0;
    latency      = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_cin       = 1'b0;
    out_ready    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
    checkOutput("rst_out_cout",  32'(out_cout),  32'd0);
    checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x1234 + 0x0FFF with latency check
    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    waitResult();
    checkOutput("basic_latency", 32'(latency), 32'd4);
    checkOutput("basic_sum_const", 32'(out_sum), 32'h2233);
    checkResult("basic", 16'h1234, 16'h0FFF, 1'b0);
    consumeResult("basic");

    // Carry-out and carry-in boundaries
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitResult();
    checkOutput("wrap_cout_const", 32'({out_cout, out_sum}), 32'h10000);
    checkResult("wrap", 16'hFFFF, 16'h0001, 1'b0);
    consumeResult("wrap");

    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitResult();
    checkOutput("cin_cout_const", 32'({out_ovf, out_cout, out_sum}), 32'h10000);
    checkResult("cin", 16'hFFFF, 16'h0000, 1'b1);
    consumeResult("cin");

    // Signed overflow boundaries
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    waitResult();
    checkOutput("posovf_const", 32'({out_ovf, out_cout, out_sum}), 32'h28000);
    checkResult("posovf", 16'h7FFF, 16'h0001, 1'b0);
    consumeResult("posovf");

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    waitResult();
    checkOutput("negovf_const", 32'({out_ovf, out_cout, out_sum}), 32'h30000);
    checkResult("negovf", 16'h8000, 16'h8000, 1'b0);
    consumeResult("negovf");

    // Backpressure with a new request waiting
    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    waitResult();
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid",    32'(out_valid), 32'd1);
      checkOutput("bp_sum",      32'(out_sum),   32'h2233);
      checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_not_taken_busy", 32'(busy),     32'd0);
    checkOutput("bp_ready_after",    32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_taken_busy", 32'(busy), 32'd1);
    waitResult();
    checkOutput("bp_new_latency", 32'(latency), 32'd4);
    checkOutput("bp_new_sum_const", 32'(out_sum), 32'h3333);
    checkResult("bp_new", 16'h1111, 16'h2222, 1'b0);
    consumeResult("bp_new");

    // Reset during RUN at k=2
    applyStimulus(16'h1234, 16'h0FFF, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_partial_sum", 32'(out_sum), 32'h0033);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready),  32'd1);
    checkOutput("mid_rst_sum",   32'(out_sum),   32'd0);
    checkOutput("mid_rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    waitResult();
    checkOutput("post_rst_sum_const", 32'(out_sum), 32'h0002);
    checkResult("post_rst", 16'h0001, 16'h0001, 1'b0);
    consumeResult("post_rst");

    // Back-to-back random stream with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc);
      if (i > 0) begin
        checkOutput("stream_ii", 32'(accept_cycle - prev_accept), 32'd6);
      end
      prev_accept = accept_cycle;
      waitResult();
      checkOutput("stream_latency", 32'(latency), 32'd4);
      checkResult("stream", ra, rb, rc);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("stream_end_idle", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_add16.md
# serial_add16

Multi-nibble serial adder sequencer that sits directly upstream of the 4-bit `my_add` ripple adder. It accepts wide operands over a valid/ready handshake and feeds them to one `my_add` instance one nibble per cycle, LSB first. Between nibbles it registers the carry, assembles the wide sum, and presents sum, carry-out and signed overflow over a second valid/ready handshake. It lets the existing 4-bit adder serve 16-bit (parameterisable) datapaths at the cost of latency.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept an operand; high only in IDLE.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `in_cin`  in  1  carry-in to nibble 0.
- `out_valid`  out  1  result valid; held until consumed.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  W  A + B + cin, modulo 2^W.
- `out_cout`  out  1  carry out of the MSB nibble.
- `out_ovf`  out  1  two's-complement overflow: `a[W-1]==b[W-1]` and `sum[W-1]!=a[W-1]`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. When `in_valid & in_ready`, the block latches `in_a`, `in_b` and `in_cin` into the operand registers, clears the nibble index to 0 and the sum register to 0, then moves to RUN.
- RUN: slice k (index k) of the latched A and B drives `my_add.a` and `my_add.b`. The carry register drives `ci` (it holds the latched cin for k=0). Each edge writes `my_add.s` into sum bits [4k+3:4k] and `my_add.co` into the carry register, then increments k. On the edge where k=NIBBLES-1 the FSM moves to DONE and `out_cout` takes the final carry.
- DONE: `out_valid`=1. `out_sum`, `out_cout` and `out_ovf` stay stable. On `out_valid & out_ready` the FSM returns to IDLE.
- `in_valid` is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Width rules: the index counter is ceil(log2(NIBBLES)) bits. The sum register is W bits and is written one nibble at a time. There is no wrap of k beyond NIBBLES-1.
- Reset, asserted at any time including mid-RUN or DONE with a pending result: the FSM goes to IDLE and the in-flight result is discarded. Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `busy`=0, carry register 0, index 0.

## Timing
- Acceptance edge is edge 0. Nibble k is summed on edge k+1. `out_valid` rises after edge NIBBLES, which is 4 cycles for the default.
- The result handshake edge returns the FSM to IDLE. `in_ready` is high from the next cycle, so there is no same-cycle re-accept.
- Minimum initiation interval is NIBBLES+2 cycles (6 for the default).
- Backpressure: `out_valid` is held for any number of cycles while `out_ready`=0. Outputs do not glitch.
- `my_add` is combinational. The critical path is operand slice mux → 4-bit ripple → sum/carry registers.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Package `serial_add_pkg` holds the state enum (IDLE, RUN, DONE) and the constant `NIBBLE_W`=4.
- The only sub-module is one instance of the existing `my_add` (ports a, b, ci, s, co).
- Slice mux, index counter, carry register, sum register and FSM are local to `serial_add16`.

## Test plan
- `0x1234 + 0x0FFF`, cin=0 → `out_sum`=0x2233, cout=0, ovf=0; `out_valid` 4 cycles after acceptance.
- `0xFFFF + 0x0001`, cin=0 → sum=0x0000, cout=1, ovf=0. Also `0xFFFF + 0x0000`, cin=1 → sum=0x0000, cout=1.
- `0x7FFF + 0x0001`, cin=0 → sum=0x8000, cout=0, ovf=1. Also `0x8000 + 0x8000` → sum=0x0000, cout=1, ovf=1.
- Hold `out_ready`=0 for 5 cycles with sum=0x2233 pending, while `in_valid`=1 with new operands → result stable, `in_ready`=0, and the new operands are accepted only after the result handshake.
- Assert `rst_n`=0 during RUN (k=2) of `0x1234 + 0x0FFF` → immediately `out_valid`=0, `in_ready`=1, `out_sum`=0. A subsequent `0x0001 + 0x0001` gives 0x0002.
- Back-to-back stream of 8 random operand pairs with `out_ready`=1 → every result matches the modulo-2^16 reference, and the initiation interval is exactly 6 cycles.
